// File: rtl/gray_pkg.sv
// Shared constants, FP32 field layout and state encodings for the grayscale
// float-to-u8 output stage.
package gray_pkg;

    localparam int unsigned FP_W       = 32;
    localparam int unsigned SIGN_POS   = 31;
    localparam int unsigned EXP_MSB    = 30;
    localparam int unsigned EXP_LSB    = 23;
    localparam int unsigned EXP_W      = 8;
    localparam int unsigned MANT_W     = 23;
    localparam int unsigned SIG_W      = MANT_W + 1;
    localparam int unsigned EXP_BIAS   = 127;
    localparam int unsigned EXP_MAX    = 255;
    localparam int unsigned EXP_SAT    = 135;
    localparam int unsigned SHIFT_BASE = 150;
    localparam int unsigned PIX_W      = 8;
    localparam int unsigned SHAMT_W    = 5;
    // Any shift beyond the significand leaves integer, guard and sticky at their final values
    localparam int unsigned SHAMT_MAX  = SIG_W + 1;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } fp32_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CAPT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CLS_ZERO = 2'd0,
        CLS_SAT  = 2'd1,
        CLS_NORM = 2'd2
    } cls_t;

endpackage

// File: rtl/fp32_to_u8_pipe.sv
// Three-stage FP32 -> u8 converter (round half to even, saturating) that carries
// valid, pixel index and end-of-frame flag alongside the data.
module fp32_to_u8_pipe
    import gray_pkg::*;
#(
    parameter int unsigned IDX_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [FP_W-1:0]  in_data,
    input  logic [IDX_W-1:0] in_idx,
    input  logic             in_last,
    output logic             out_valid,
    output logic [PIX_W-1:0] out_pix,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last
);

    fp32_t f;
    assign f = fp32_t'(in_data);

    // Stage 1: classify and compute the alignment shift
    cls_t               c1_cls;
    logic [SHAMT_W-1:0] c1_shamt;

    always_comb begin
        c1_cls   = CLS_NORM;
        c1_shamt = SHAMT_W'(SHAMT_MAX);
        if (f.sign || (f.exp == '0)) begin
            c1_cls = CLS_ZERO;
        end else if (f.exp == EXP_W'(EXP_MAX)) begin
            c1_cls = (f.mant == '0) ? CLS_SAT : CLS_ZERO;
        end else if (f.exp >= EXP_W'(EXP_SAT)) begin
            c1_cls = CLS_SAT;
        end
        if (f.exp > EXP_W'(SHIFT_BASE - SHAMT_MAX)) begin
            c1_shamt = SHAMT_W'(EXP_W'(SHIFT_BASE) - f.exp);
        end
    end

    logic               s1_valid;
    logic [IDX_W-1:0]   s1_idx;
    logic               s1_last;
    cls_t               s1_cls;
    logic [SIG_W-1:0]   s1_sig;
    logic [SHAMT_W-1:0] s1_shamt;

    // Stage 2: align, extract guard and sticky
    logic [SHAMT_W-1:0] c2_gpos;
    logic [PIX_W-1:0]   c2_int;
    logic               c2_guard;
    logic               c2_sticky;

    always_comb begin
        c2_gpos   = s1_shamt - SHAMT_W'(1);
        c2_int    = PIX_W'(s1_sig >> s1_shamt);
        c2_guard  = 1'(s1_sig >> c2_gpos);
        c2_sticky = |(s1_sig & ((SIG_W'(1) << c2_gpos) - SIG_W'(1)));
    end

    logic             s2_valid;
    logic [IDX_W-1:0] s2_idx;
    logic             s2_last;
    cls_t             s2_cls;
    logic [PIX_W-1:0] s2_int;
    logic             s2_guard;
    logic             s2_sticky;

    // Stage 3: round half to even; a carry into bit 8 means 256, which saturates
    logic             c3_round_up;
    logic [PIX_W:0]   c3_sum;
    logic [PIX_W-1:0] c3_pix;

    always_comb begin
        c3_round_up = s2_guard & (s2_sticky | s2_int[0]);
        c3_sum      = {1'b0, s2_int} + (PIX_W + 1)'(c3_round_up);
        c3_pix      = '0;
        case (s2_cls)
            CLS_SAT:  c3_pix = '1;
            CLS_NORM: c3_pix = c3_sum[PIX_W] ? '1 : c3_sum[PIX_W-1:0];
            default:  c3_pix = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_idx    <= '0;
            s1_last   <= 1'b0;
            s1_cls    <= CLS_ZERO;
            s1_sig    <= '0;
            s1_shamt  <= '0;
            s2_valid  <= 1'b0;
            s2_idx    <= '0;
            s2_last   <= 1'b0;
            s2_cls    <= CLS_ZERO;
            s2_int    <= '0;
            s2_guard  <= 1'b0;
            s2_sticky <= 1'b0;
            out_valid <= 1'b0;
            out_pix   <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
        end else begin
            s1_valid  <= in_valid;
            s1_idx    <= in_idx;
            s1_last   <= in_valid & in_last;
            s1_cls    <= c1_cls;
            s1_sig    <= {1'b1, f.mant};
            s1_shamt  <= c1_shamt;

            s2_valid  <= s1_valid;
            s2_idx    <= s1_idx;
            s2_last   <= s1_valid & s1_last;
            s2_cls    <= s1_cls;
            s2_int    <= c2_int;
            s2_guard  <= c2_guard;
            s2_sticky <= c2_sticky;

            out_valid <= s2_valid;
            out_last  <= s2_valid & s2_last;
            if (s2_valid) begin
                out_pix <= c3_pix;
                out_idx <= s2_idx;
            end
        end
    end

endmodule

// File: rtl/gray_fp2u8.sv
// Grayscale frame sink: detects the upstream done edge, captures NPIX FP32 pixels
// and streams them out as indexed u8 pixels with an end-of-frame pulse.
module gray_fp2u8
    import gray_pkg::*;
#(
    parameter int unsigned NPIX  = 1024,
    parameter int unsigned IDX_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      Gray,
    output logic             out_valid,
    output logic [7:0]       out_pix,
    output logic [IDX_W-1:0] out_idx,
    output logic             busy,
    output logic             frame_done
);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NPIX - 1);
    localparam int unsigned      DRAIN_CYC = 3;

    state_t           state;
    logic [IDX_W-1:0] cnt;
    logic [1:0]       dcnt;
    logic             start_q;
    logic             sq_valid;
    logic             cap_valid;
    logic [FP_W-1:0]  cap_data;
    logic [IDX_W-1:0] cap_idx;
    logic             cap_last;

    // start_q is only trusted once it has sampled start after reset, so a level
    // held high across reset is not mistaken for a fresh edge
    logic start_rise_c;
    logic frame_go_c;
    assign start_rise_c = start & ~start_q & sq_valid;
    assign frame_go_c   = start_rise_c && (state == ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q  <= 1'b0;
            sq_valid <= 1'b0;
        end else begin
            start_q  <= start;
            sq_valid <= 1'b1;
        end
    end

    // Frame FSM with capture register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            dcnt      <= '0;
            cap_valid <= 1'b0;
            cap_data  <= '0;
            cap_idx   <= '0;
            cap_last  <= 1'b0;
        end else begin
            cap_valid <= 1'b0;
            cap_last  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (frame_go_c) begin
                        cap_valid <= 1'b1;
                        cap_data  <= Gray;
                        cap_idx   <= '0;
                        cnt       <= IDX_W'(1);
                        state     <= ST_CAPT;
                    end
                end
                ST_CAPT: begin
                    cap_valid <= 1'b1;
                    cap_data  <= Gray;
                    cap_idx   <= cnt;
                    if (cnt == LAST_IDX) begin
                        cap_last <= 1'b1;
                        cnt      <= '0;
                        dcnt     <= '0;
                        state    <= ST_DRAIN;
                    end else begin
                        cnt <= cnt + IDX_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (dcnt == 2'(DRAIN_CYC - 1)) begin
                        dcnt  <= '0;
                        state <= ST_IDLE;
                    end else begin
                        dcnt <= dcnt + 2'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // busy spans from the start edge through the cycle carrying frame_done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
        end else if (frame_go_c) begin
            busy <= 1'b1;
        end else if (frame_done) begin
            busy <= 1'b0;
        end
    end

    fp32_to_u8_pipe #(
        .IDX_W (IDX_W)
    ) u_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (cap_valid),
        .in_data   (cap_data),
        .in_idx    (cap_idx),
        .in_last   (cap_last),
        .out_valid (out_valid),
        .out_pix   (out_pix),
        .out_idx   (out_idx),
        .out_last  (frame_done)
    );

endmodule

// File: tb/tb_gray_fp2u8.sv
// Randomized self-checking bench for gray_fp2u8 against a real-arithmetic reference.
module tb_gray_fp2u8;

    localparam int NPIX  = 1024;
    localparam int IDX_W = 10;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [31:0]      Gray;
    logic             out_valid;
    logic [7:0]       out_pix;
    logic [IDX_W-1:0] out_idx;
    logic             busy;
    logic             frame_done;

    always #5 clk = ~clk;

    gray_fp2u8 #(
        .NPIX  (NPIX),
        .IDX_W (IDX_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .Gray       (Gray),
        .out_valid  (out_valid),
        .out_pix    (out_pix),
        .out_idx    (out_idx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] frame_pix [NPIX];
    int          frame_exp [NPIX];

    // Reference: decode the float value with real arithmetic, then round half to even
    function automatic int ref_u8(input logic [31:0] b);
        int  e;
        int  m;
        int  r;
        real v;
        real fl;
        real fr;
        e = int'(b[30:23]);
        m = int'(b[22:0]);
        if (b[31]) return 0;
        if (e == 0) return 0;
        if (e == 255) return (m == 0) ? 255 : 0;
        v = (1.0 + real'(m) / 8388608.0) * (2.0 ** real'(e - 127));
        if (v >= 255.5) return 255;
        fl = $floor(v);
        fr = v - fl;
        r  = int'(fl);
        if (fr > 0.5) r = r + 1;
        else if ((fr == 0.5) && ((r % 2) == 1)) r = r + 1;
        return r;
    endfunction

    function automatic logic [31:0] int_to_fp(input int n);
        int          p;
        logic [31:0] b;
        if (n == 0) return 32'd0;
        p        = $clog2(n + 1) - 1;
        b        = '0;
        b[30:23] = 8'(127 + p);
        b[22:0]  = 23'(n << (23 - p));
        return b;
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] b;
        int          sel;
        b   = $urandom();
        sel = int'($urandom_range(0, 9));
        if (sel >= 1 && sel <= 7) begin
            b[31]    = 1'b0;
            b[30:23] = 8'($urandom_range(120, 136));
            if (sel < 4) b[14:0] = '0;
        end else if (sel == 8) begin
            b[30:23] = 8'hFF;
        end
        return b;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < NPIX; i++) begin
            frame_pix[i] = rand_fp();
            frame_exp[i] = ref_u8(frame_pix[i]);
        end
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < NPIX; i++) begin
            frame_pix[i] = int_to_fp(i % 256);
            frame_exp[i] = i % 256;
        end
    endtask

    // Drives one frame from the negedge it is called on; stops early after cycle stop_at
    task automatic run_frame(input string tag, input int pulse_at, input int stop_at,
                             output int n_out);
        int   k;
        logic exp_v;
        logic exp_fd;
        logic exp_busy;
        n_out = 0;
        start = 1'b1;
        Gray  = frame_pix[0];
        for (int c = 0; c <= NPIX + 3; c++) begin
            @(negedge clk);
            k        = c - 3;
            exp_v    = (k >= 0) && (k < NPIX);
            exp_fd   = (k == NPIX - 1);
            exp_busy = (c < NPIX + 3);
            if (out_valid === 1'b1) n_out++;
            checks++;
            if (out_valid !== exp_v) begin
                errors++;
                $display("FAIL %s out_valid c=%0d got %b exp %b", tag, c, out_valid, exp_v);
            end
            checks++;
            if (frame_done !== exp_fd) begin
                errors++;
                $display("FAIL %s frame_done c=%0d got %b exp %b", tag, c, frame_done, exp_fd);
            end
            checks++;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL %s busy c=%0d got %b exp %b", tag, c, busy, exp_busy);
            end
            if (exp_v) begin
                checks++;
                if (out_idx !== IDX_W'(k)) begin
                    errors++;
                    $display("FAIL %s out_idx c=%0d got %0d exp %0d", tag, c, out_idx, k);
                end
                checks++;
                if (out_pix !== 8'(frame_exp[k])) begin
                    errors++;
                    $display("FAIL %s out_pix idx=%0d in=%h got %0d exp %0d",
                             tag, k, frame_pix[k], out_pix, frame_exp[k]);
                end
            end
            if (c == stop_at) break;
            Gray = (c + 1 < NPIX) ? frame_pix[c + 1] : $urandom();
            if (c == pulse_at - 2) start = 1'b0;
            if (c == pulse_at) start = 1'b1;
            if (c == NPIX) start = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        Gray  = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({out_valid, out_pix, out_idx, busy, frame_done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b pix=%0d idx=%0d busy=%b fd=%b exp all 0",
                     out_valid, out_pix, out_idx, busy, frame_done);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({out_valid, busy, frame_done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_idle got v=%b busy=%b fd=%b exp 0", out_valid, busy, frame_done);
        end
    endtask

    // Each value is pixel 0 of a frame that is then aborted by reset
    task automatic test_values();
        logic [31:0] vals [11] = '{32'h43000000, 32'h42FF0000, 32'h40200000, 32'h3F400000,
                                   32'h3F000000, 32'hBF800000, 32'h80000000, 32'h7FC00000,
                                   32'h7F800000, 32'h437F8000, 32'h437F0000};
        int          exps [11] = '{128, 128, 2, 1, 0, 0, 0, 0, 255, 255, 255};
        logic [31:0] v;
        int          ev;
        for (int i = 0; i < 71; i++) begin
            if (i < 11) begin
                v  = vals[i];
                ev = exps[i];
            end else begin
                v  = rand_fp();
                ev = ref_u8(v);
            end
            start = 1'b1;
            Gray  = v;
            @(negedge clk);
            Gray = $urandom();
            repeat (2) @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL value_early_valid in=%h got %b exp 0", v, out_valid);
            end
            @(negedge clk);
            checks++;
            if ({out_valid, out_idx} !== {1'b1, IDX_W'(0)}) begin
                errors++;
                $display("FAIL value_valid in=%h got v=%b idx=%0d exp v=1 idx=0", v, out_valid, out_idx);
            end
            checks++;
            if (out_pix !== 8'(ev)) begin
                errors++;
                $display("FAIL value_pix in=%h got %0d exp %0d", v, out_pix, ev);
            end
            rst_n = 1'b0;
            start = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_ramp_frame();
        int n;
        fill_ramp();
        run_frame("ramp", -1, -1, n);
        checks++;
        if (n != NPIX) begin
            errors++;
            $display("FAIL ramp_count got %0d exp %0d", n, NPIX);
        end
    endtask

    task automatic test_restart_ignored();
        int n;
        fill_random();
        run_frame("restart", 500, -1, n);
        checks++;
        if (n != NPIX) begin
            errors++;
            $display("FAIL restart_count got %0d exp %0d", n, NPIX);
        end
    endtask

    task automatic test_reset_midframe();
        int n;
        fill_random();
        run_frame("abort", -1, 300, n);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid, busy, frame_done} !== 3'b000) begin
            errors++;
            $display("FAIL abort_in_reset got v=%b busy=%b fd=%b exp 0", out_valid, busy, frame_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if ({out_valid, busy, frame_done} !== 3'b000) begin
                errors++;
                $display("FAIL abort_after_release c=%0d got v=%b busy=%b fd=%b exp 0",
                         c, out_valid, busy, frame_done);
            end
        end
        start = 1'b0;
        @(negedge clk);
        fill_random();
        run_frame("post_abort", -1, -1, n);
        checks++;
        if (n != NPIX) begin
            errors++;
            $display("FAIL post_abort_count got %0d exp %0d", n, NPIX);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        fill_random();
        run_frame("b2b_first", -1, -1, n);
        checks++;
        if (n != NPIX) begin
            errors++;
            $display("FAIL b2b_first_count got %0d exp %0d", n, NPIX);
        end
        fill_ramp();
        run_frame("b2b_second", -1, -1, n);
        checks++;
        if (n != NPIX) begin
            errors++;
            $display("FAIL b2b_second_count got %0d exp %0d", n, NPIX);
        end
    endtask

    initial begin
        test_reset();
        test_values();
        test_ramp_frame();
        test_restart_ignored();
        test_reset_midframe();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gray_fp2u8.md
# gray_fp2u8

Downstream stage of the RGB-to-grayscale converter. Consumes the grayscale frame it streams out as IEEE-754 single-precision words (one per clock after its `done` rises) and converts each pixel to 8-bit unsigned by round-half-to-even with saturation. Emits an indexed 8-bit pixel stream and an end-of-frame pulse for the image writer / display buffer that follows.

## Interface
- `NPIX`, 1024 — pixels per frame (power of two, ≥ 4)
- `IDX_W`, 10 — width of pixel index, = log2(NPIX)

Ports:
- `clk`  in  1 — single clock, rising edge
- `rst_n`  in  1 — asynchronous, active-low reset
- `start`  in  1 — connected to upstream `done`; its rising edge opens a frame
- `Gray`  in  32 — IEEE-754 single grayscale pixel, nominal range 0.0–255.0
- `out_valid`  out  1 — `out_pix`/`out_idx` valid this cycle
- `out_pix`  out  8 — converted pixel
- `out_idx`  out  IDX_W — pixel index in the frame, 0 … NPIX-1
- `busy`  out  1 — frame in progress (capturing or draining)
- `frame_done`  out  1 — one-cycle pulse with the last `out_valid` of the frame

## Operation
- FSM states: IDLE, CAPT, DRAIN.
- IDLE → CAPT when `start` is high and `start_q` (registered `start`) is low. `Gray` is captured on that same edge as pixel 0.
- CAPT: captures `Gray` on every rising edge. The capture counter increments per edge. After pixel NPIX-1 is captured, go to DRAIN.
- DRAIN: 3 cycles until the pipeline empties, then IDLE.
- Rising edges of `start` outside IDLE are ignored and do not restart the frame.
- Conversion rules, applied per pixel from sign s, exponent e (8 bits), and mantissa m (23 bits):
  - s = 1, including −0 → 0
  - e = 0 (zero or denormal) → 0
  - e = 255 with m ≠ 0 (NaN) → 0
  - e = 255 with m = 0 (+Inf) → 255
  - value ≥ 255.5 → 255, because 255.5 rounds to even 256 and saturates
  - otherwise: integer = ({1,m} >> (150−e)), then round half to even using the guard bit and the sticky OR of the lower bits
  - values < 0.5 → 0; exactly 0.5 → 0
  - e ≥ 135 (value ≥ 256) → 255 without shifting
- Arithmetic: the shift operand is 24 bits wide. Round-up carry is computed in 9 bits, and values above 255 saturate.
- `out_idx` equals the capture index of that pixel and is carried alongside the data through the pipeline.

## Timing
- Latency is exactly 3 cycles, capture edge to output:
  - stage 1: unpack and classify
  - stage 2: align shift, guard, sticky
  - stage 3: round, saturate, register outputs
- Throughput is 1 pixel per clock. There is no back-pressure.
- The pixel captured on edge k is output with `out_valid` = 1 after edge k+3.
- `frame_done` is high in the same cycle as `out_idx` = NPIX-1 and `out_valid` = 1.
- `busy` rises after the start edge. It falls after the edge on which `frame_done` was high.
- A new frame can start on the first edge with the FSM back in IDLE and a fresh rising edge of `start`.
- Reset values: `out_valid` = 0, `out_pix` = 0, `out_idx` = 0, `busy` = 0, `frame_done` = 0, `start_q` = 0, FSM = IDLE, counter = 0, all pipeline valid bits = 0.
- Reset mid-frame: all pipeline valid bits clear at once, partial output is discarded, and no `frame_done` is produced. After release, a fresh `start` rising edge is required; a `start` already held high does not start a frame.
- The capture counter wraps NPIX-1 → 0 only at the frame end. `out_idx` never exceeds NPIX-1.

## Structure
- Shared package `gray_pkg`:
  - FP32 field widths and positions (sign 31, exp 30:23, mant 22:0) and bias 127
  - constants `EXP_MAX` = 255, `EXP_SAT` = 135, `SHIFT_BASE` = 150
  - FSM state encoding for IDLE, CAPT, DRAIN
- One sub-module, `fp32_to_u8_pipe`: the 3-stage conversion datapath carrying valid, index, and last flags.
- The top level holds the start edge detect, FSM, counter, `busy`, and `frame_done`.

## Test plan
- Exact and rounding values, each driven as pixel 0:
  - 0x43000000 (128.0) → 128
  - 0x42FF0000 (127.5) → 128
  - 0x40200000 (2.5) → 2
  - 0x3F400000 (0.75) → 1
  - 0x3F000000 (0.5) → 0
- Special values:
  - 0xBF800000 (−1.0) → 0
  - 0x80000000 (−0) → 0
  - 0x7FC00000 (NaN) → 0
  - 0x7F800000 (+Inf) → 255
  - 0x437F8000 (255.5) → 255
  - 0x437F0000 (255.0) → 255
- Full frame: 1024 pixels with ramp `Gray` = float(i mod 256), starting at the upstream `done` rising edge.
  - `out_pix` = i mod 256 and `out_idx` = i, with the first `out_valid` 3 cycles after the start edge.
  - `frame_done` is a single pulse at idx 1023; `busy` drops on the next cycle.
- Second `start` pulse at pixel 500 → ignored; the indices stay contiguous and exactly 1024 outputs are produced.
- `rst_n` asserted at pixel 300, held 2 cycles, and released with `start` still high:
  - no further outputs and no `frame_done`
  - the next `start` low→high runs a clean 1024-pixel frame
- Back-to-back frames with `start` re-pulsed right after `busy` falls → the second frame outputs idx 0–1023 correctly.
